// File: rtl/rgb_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module      : rgb_pwm_driver
// Description : Three RGB LEDs driven by nine 8-bit PWM channels, with
//               shadow/active duty registers updated at each PWM wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_pwm_driver #(
  parameter int CLOCK_FREQUENCY = 80000000,
  parameter int PWM_FREQUENCY   = 1000
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Cmd_Valid,
  input  logic [1:0] i_Cmd_Op,
  input  logic [1:0] i_Cmd_LED,
  input  logic [1:0] i_Cmd_Colour,
  input  logic [7:0] i_Cmd_Level,
  output logic       o_Cmd_Ready,
  output logic       o_Cmd_Error,
  output logic       o_Period_Start,
  output logic [8:0] o_LED
);

  localparam int PRESCALE_RAW = CLOCK_FREQUENCY / (PWM_FREQUENCY * 255);
  localparam int PRESCALE     = (PRESCALE_RAW < 1) ? 1 : PRESCALE_RAW;
  localparam int PS_W         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [7:0]      CNT_LAST = 8'd254;
  localparam logic [1:0] OP_SET     = 2'b00;
  localparam logic [1:0] OP_TOGGLE  = 2'b01;
  localparam logic [1:0] OP_ALL_OFF = 2'b10;
  localparam logic [1:0] OP_BAD     = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_DECODE = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [1:0]        led_sel_q, led_sel_d;
  logic [1:0]        colour_q, colour_d;
  logic [7:0]        level_q, level_d;
  logic [PS_W-1:0]   presc_q, presc_d;
  logic [7:0]        count_q, count_d;
  logic [8:0][7:0]   shadow_q, shadow_d;
  logic [8:0][7:0]   active_q, active_d;
  logic [8:0]        pwm_q, pwm_d;
  logic              err_q, err_d;
  logic              pstart_q, pstart_d;

  logic              tick;
  logic              wrap;
  logic              cmd_bad;
  logic [3:0]        chan;

  assign tick    = (presc_q == PS_LAST);
  assign wrap    = tick && (count_q == CNT_LAST);
  // Channel index = LED*3 + colour, formed as LED*2 + LED + colour.
  assign chan    = {1'b0, led_sel_q, 1'b0} + {2'b00, led_sel_q} + {2'b00, colour_q};
  // Colour is irrelevant to all-off, so colour 3 only rejects set/toggle.
  assign cmd_bad = (op_q == OP_BAD) || (led_sel_q == 2'd3) ||
                   ((op_q != OP_ALL_OFF) && (colour_q == 2'd3));

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    led_sel_d = led_sel_q;
    colour_d  = colour_q;
    level_d   = level_q;
    presc_d   = tick ? '0 : presc_q + PS_W'(1);
    count_d   = count_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    err_d     = 1'b0;
    pstart_d  = 1'b0;
    pwm_d     = '0;

    if (tick) begin
      count_d = wrap ? 8'd0 : count_q + 8'd1;
    end
    // Active loads the pre-write shadow; a same-edge command write lands after.
    if (wrap) begin
      active_d = shadow_q;
      pstart_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_Cmd_Valid) begin
          state_d   = ST_DECODE;
          op_d      = i_Cmd_Op;
          led_sel_d = i_Cmd_LED;
          colour_d  = i_Cmd_Colour;
          level_d   = i_Cmd_Level;
        end
      end
      ST_DECODE: begin
        state_d = ST_IDLE;
        if (cmd_bad) begin
          err_d = 1'b1;
        end else begin
          case (op_q)
            OP_SET:    shadow_d[chan] = level_q;
            OP_TOGGLE: shadow_d[chan] = (shadow_q[chan] == 8'd0) ? level_q : 8'd0;
            default: begin
              shadow_d = '0;
              active_d = '0;
            end
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase

    for (int i = 0; i < 9; i++) begin
      pwm_d[i] = (count_d < active_d[i]);
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q   <= ST_IDLE;
      op_q      <= 2'b00;
      led_sel_q <= 2'b00;
      colour_q  <= 2'b00;
      level_q   <= 8'd0;
      presc_q   <= '0;
      count_q   <= 8'd0;
      shadow_q  <= '0;
      active_q  <= '0;
      pwm_q     <= '0;
      err_q     <= 1'b0;
      pstart_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      led_sel_q <= led_sel_d;
      colour_q  <= colour_d;
      level_q   <= level_d;
      presc_q   <= presc_d;
      count_q   <= count_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pwm_q     <= pwm_d;
      err_q     <= err_d;
      pstart_q  <= pstart_d;
    end
  end

  assign o_Cmd_Ready    = (state_q == ST_IDLE);
  assign o_Cmd_Error    = err_q;
  assign o_Period_Start = pstart_q;
  assign o_LED          = pwm_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb_pwm_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_rgb_pwm_driver
// Description : Self-checking bench for rgb_pwm_driver with a time-based
//               reference model and directed scenario checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb_pwm_driver;

  localparam int CF     = 2550;
  localparam int PF     = 10;
  localparam int PS_RAW = CF / (PF * 255);
  localparam int PS     = (PS_RAW < 1) ? 1 : PS_RAW;
  localparam int PERIOD = 255 * PS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       valid = 1'b0;
  logic [1:0] op = 2'b00;
  logic [1:0] led = 2'b00;
  logic [1:0] col = 2'b00;
  logic [7:0] lvl = 8'h00;
  logic       o_Cmd_Ready;
  logic       o_Cmd_Error;
  logic       o_Period_Start;
  logic [8:0] o_LED;

  int checks = 0;
  int errors = 0;

  rgb_pwm_driver #(
    .CLOCK_FREQUENCY(CF),
    .PWM_FREQUENCY  (PF)
  ) dut (
    .i_Clock       (clk),
    .i_Reset_n     (rst_n),
    .i_Cmd_Valid   (valid),
    .i_Cmd_Op      (op),
    .i_Cmd_LED     (led),
    .i_Cmd_Colour  (col),
    .i_Cmd_Level   (lvl),
    .o_Cmd_Ready   (o_Cmd_Ready),
    .o_Cmd_Error   (o_Cmd_Error),
    .o_Period_Start(o_Period_Start),
    .o_LED         (o_LED)
  );

  always #5 clk = ~clk;

  // Reference model: counter position follows from edges since reset release.
  int t;
  int m_shadow[9];
  int m_active[9];
  int old_sh[9];
  bit m_busy, m_err, m_ps, m_wrap;
  int p_op, p_led, p_col, p_lvl;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t = 0;
      for (int i = 0; i < 9; i++) begin
        m_shadow[i] = 0;
        m_active[i] = 0;
      end
      m_busy = 0; m_err = 0; m_ps = 0;
    end else begin
      t++;
      m_wrap = ((t % PERIOD) == 0);
      old_sh = m_shadow;
      if (m_wrap) m_active = old_sh;
      m_ps  = m_wrap;
      m_err = 0;
      if (m_busy) begin
        m_busy = 0;
        if (p_op == 3 || p_led == 3 || (p_op != 2 && p_col == 3)) m_err = 1;
        else if (p_op == 0) m_shadow[p_led*3 + p_col] = p_lvl;
        else if (p_op == 1) m_shadow[p_led*3 + p_col] = (old_sh[p_led*3 + p_col] == 0) ? p_lvl : 0;
        else begin
          for (int i = 0; i < 9; i++) begin
            m_shadow[i] = 0;
            m_active[i] = 0;
          end
        end
      end else if (valid) begin
        m_busy = 1;
        p_op = int'(op); p_led = int'(led); p_col = int'(col); p_lvl = int'(lvl);
      end
    end
  end

  function automatic logic [8:0] model_led();
    logic [8:0] v;
    int cnt;
    cnt = (t / PS) % 255;
    for (int i = 0; i < 9; i++) v[i] = (cnt < m_active[i]);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_led", int'(o_LED), int'(model_led()));
    chk("model_ready", int'(o_Cmd_Ready), int'(!m_busy));
    chk("model_error", int'(o_Cmd_Error), int'(m_err));
    chk("model_pstart", int'(o_Period_Start), int'(m_ps));
  end

  task automatic garbage();
    op  = 2'($urandom);
    led = 2'($urandom);
    col = 2'($urandom);
    lvl = 8'($urandom);
  endtask

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      valid = 1'b0;
      garbage();
    end
  endtask

  task automatic send(input logic [1:0] s_op, input logic [1:0] s_led,
                      input logic [1:0] s_col, input logic [7:0] s_lvl);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_Cmd_Ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready_wait", int'(o_Cmd_Ready), 1);
    valid = 1'b1; op = s_op; led = s_led; col = s_col; lvl = s_lvl;
    @(negedge clk);
    valid = 1'b0; garbage();
    chk("ready_low_after_accept", int'(o_Cmd_Ready), 0);
    @(negedge clk);
    garbage();
    chk("ready_back_high", int'(o_Cmd_Ready), 1);
  endtask

  task automatic wait_ps();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      valid = 1'b0; garbage();
      n++;
    end while (!o_Period_Start && n < PERIOD + 10);
    chk("period_start_seen", int'(o_Period_Start), 1);
  endtask

  task automatic count_high(input int idx, input int n, output int hi);
    hi = 0;
    for (int k = 0; k < n; k++) begin
      hi += int'(o_LED[idx]);
      @(negedge clk);
      valid = 1'b0; garbage();
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, hi, pulses;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_led", int'(o_LED), 0);
    chk("reset_ready", int'(o_Cmd_Ready), 1);
    chk("reset_error", int'(o_Cmd_Error), 0);
    chk("reset_pstart", int'(o_Period_Start), 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!o_Period_Start && n < PERIOD + 20);
    chk("first_wrap_clocks", n, 255);

    // Set LED1 green to 0x80
    send(2'b00, 2'd1, 2'd1, 8'h80);
    chk("set_before_wrap", int'(o_LED[4]), 0);
    wait_ps();
    count_high(4, 255, hi);
    chk("set_high_p1", hi, 128);
    count_high(4, 255, hi);
    chk("set_high_p2", hi, 128);

    // Toggle LED0 red twice
    send(2'b01, 2'd0, 2'd0, 8'h11);
    wait_ps();
    count_high(0, 255, hi);
    chk("toggle_on_high", hi, 17);
    send(2'b01, 2'd0, 2'd0, 8'h11);
    wait_ps();
    count_high(0, 255, hi);
    chk("toggle_off_high", hi, 0);

    // Invalid LED number
    send(2'b00, 2'd3, 2'd0, 8'hAA);
    pulses = int'(o_Cmd_Error);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pulses += int'(o_Cmd_Error);
    end
    chk("invalid_err_pulses", pulses, 1);

    // Duty 255 across wraps
    send(2'b00, 2'd2, 2'd2, 8'hFF);
    wait_ps();
    count_high(8, 600, hi);
    chk("duty255_high", hi, 600);

    // All off mid-period
    send(2'b00, 2'd0, 2'd1, 8'hFF);
    send(2'b00, 2'd1, 2'd0, 8'hFF);
    wait_ps();
    idle_n(50);
    chk("alloff_pre", int'({o_LED[8], o_LED[3], o_LED[1]}), 7);
    send(2'b10, 2'd0, 2'd0, 8'h00);
    chk("alloff_led_now", int'(o_LED), 0);
    wait_ps();
    chk("alloff_led_after_wrap", int'(o_LED), 0);

    // Collision: DECODE edge lands on the wrap edge
    send(2'b00, 2'd1, 2'd0, 8'h40);
    wait_ps();
    idle_n(253);
    chk("collide_ready", int'(o_Cmd_Ready), 1);
    valid = 1'b1; op = 2'b00; led = 2'd1; col = 2'd0; lvl = 8'hC0;
    @(negedge clk);
    valid = 1'b0; garbage();
    @(negedge clk);
    garbage();
    chk("collide_pstart", int'(o_Period_Start), 1);
    count_high(3, 255, hi);
    chk("collide_old_duty", hi, 64);
    count_high(3, 255, hi);
    chk("collide_new_duty", hi, 192);

    // Randomized traffic with one reset landing on a pending command
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (k == 1500) begin
        valid = 1'b1; op = 2'b00; led = 2'd0; col = 2'd0; lvl = 8'h55;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_reset_led", int'(o_LED), 0);
        chk("async_reset_ready", int'(o_Cmd_Ready), 1);
        chk("async_reset_pstart", int'(o_Period_Start), 0);
        valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        valid = ($urandom % 3) == 0;
        garbage();
        if (op == 2'b10 && ($urandom % 6) != 0) op = 2'b00;
        if (op == 2'b10 && led == 2'd3) led = 2'd0;
      end
    end
    @(negedge clk);
    valid = 1'b0;
    idle_n(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
